pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer.sv | 160 ++++++++++++++++
 tb/tb_pc_sequencer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: selects the next fetch PC from branch decode,
// external redirect and a circular return-address stack, and registers it on Advance.
module pc_sequencer #(
    parameter int ADDR_W    = 64,
    parameter int RAS_DEPTH = 4
) (
    input  logic                               CLK,
    input  logic                               resetl,
    input  logic [ADDR_W-1:0]                  StartPC,
    input  logic                               Advance,
    input  logic [2:0]                         BranchOp,
    input  logic [63:0]                        SignExtImm64,
    input  logic                               ALUZero,
    input  logic                               CondTrue,
    input  logic [ADDR_W-1:0]                  RegTarget,
    input  logic                               Redirect,
    input  logic [ADDR_W-1:0]                  RedirectPC,
    output logic [ADDR_W-1:0]                  CurrentPC,
    output logic [ADDR_W-1:0]                  NextPC,
    output logic                               Taken,
    output logic [$clog2(RAS_DEPTH+1)-1:0]     RasCount,
    output logic                               RasUnderflow
);

    localparam int CNT_W = $clog2(RAS_DEPTH + 1);
    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(RAS_DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(RAS_DEPTH);

    typedef enum logic [2:0] {
        OP_SEQ   = 3'b000,
        OP_B     = 3'b001,
        OP_CBZ   = 3'b010,
        OP_CBNZ  = 3'b011,
        OP_BCOND = 3'b100,
        OP_BL    = 3'b101,
        OP_BR    = 3'b110,
        OP_RET   = 3'b111
    } op_e;

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              taken_q, taken_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              unf_q, unf_d;
    logic [PTR_W-1:0]  tos_q, tos_d;
    logic [ADDR_W-1:0] ras_q [RAS_DEPTH];

    logic [ADDR_W-1:0] seq_pc, rel_pc, next_pc;
    logic [PTR_W-1:0]  push_ptr, pop_ptr;
    logic              take, push, pop, unf_set;
    op_e               op;

    assign op       = op_e'(BranchOp);
    assign seq_pc   = pc_q + ADDR_W'(4);
    assign rel_pc   = pc_q + (SignExtImm64[ADDR_W-1:0] << 2);
    assign push_ptr = (tos_q == LAST_PTR) ? '0 : tos_q + PTR_W'(1);
    assign pop_ptr  = (tos_q == '0) ? LAST_PTR : tos_q - PTR_W'(1);

    // Target selection; Redirect suppresses every RAS side effect.
    always_comb begin
        next_pc = seq_pc;
        take    = 1'b0;
        push    = 1'b0;
        pop     = 1'b0;
        unf_set = 1'b0;
        if (Redirect) begin
            next_pc = RedirectPC;
            take    = 1'b1;
        end else begin
            case (op)
                OP_B: begin
                    next_pc = rel_pc;
                    take    = 1'b1;
                end
                OP_BL: begin
                    next_pc = rel_pc;
                    take    = 1'b1;
                    push    = 1'b1;
                end
                OP_CBZ: begin
                    take    = ALUZero;
                    next_pc = ALUZero ? rel_pc : seq_pc;
                end
                OP_CBNZ: begin
                    take    = !ALUZero;
                    next_pc = !ALUZero ? rel_pc : seq_pc;
                end
                OP_BCOND: begin
                    take    = CondTrue;
                    next_pc = CondTrue ? rel_pc : seq_pc;
                end
                OP_BR: begin
                    next_pc = RegTarget;
                    take    = 1'b1;
                end
                OP_RET: begin
                    take = 1'b1;
                    if (cnt_q != '0) begin
                        next_pc = ras_q[tos_q];
                        pop     = 1'b1;
                    end else begin
                        next_pc = RegTarget;
                        unf_set = 1'b1;
                    end
                end
                default: next_pc = seq_pc;
            endcase
        end
    end

    always_comb begin
        pc_d    = pc_q;
        taken_d = taken_q;
        cnt_d   = cnt_q;
        tos_d   = tos_q;
        unf_d   = unf_q;
        if (Advance) begin
            pc_d    = next_pc;
            taken_d = take;
            unf_d   = unf_q | unf_set;
            if (push) begin
                tos_d = push_ptr;
                cnt_d = (cnt_q == FULL_CNT) ? cnt_q : cnt_q + CNT_W'(1);
            end else if (pop) begin
                tos_d = pop_ptr;
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!resetl) begin
            pc_q    <= StartPC;
            taken_q <= 1'b0;
            cnt_q   <= '0;
            tos_q   <= '0;
            unf_q   <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            taken_q <= taken_d;
            cnt_q   <= cnt_d;
            tos_q   <= tos_d;
            unf_q   <= unf_d;
        end
    end

    // When full, the push slot is the oldest entry, so it is overwritten in place.
    always_ff @(posedge CLK) begin
        if (resetl && Advance && push) begin
            ras_q[push_ptr] <= seq_pc;
        end
    end

    assign CurrentPC    = pc_q;
    assign NextPC       = next_pc;
    assign Taken        = taken_q;
    assign RasCount     = cnt_q;
    assign RasUnderflow = unf_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: 64-bit and 32-bit instances share stimulus and are
// checked every cycle against a queue-based model plus directed literal checks.
module tb_pc_sequencer;

    localparam int DEPTH = 4;
    localparam logic [2:0] SEQ = 3'd0, B = 3'd1, CBZ = 3'd2, CBNZ = 3'd3,
                           BCOND = 3'd4, BL = 3'd5, BR = 3'd6, RET = 3'd7;

    logic        CLK = 1'b0;
    logic        resetl;
    logic [63:0] StartPC;
    logic        Advance;
    logic [2:0]  BranchOp;
    logic [63:0] Imm;
    logic        ALUZero;
    logic        CondTrue;
    logic [63:0] RegTarget;
    logic        Redirect;
    logic [63:0] RedirectPC;

    logic [63:0] cur64, nxt64;
    logic        tk64, unf64;
    logic [2:0]  cnt64;
    logic [31:0] cur32, nxt32;
    logic        tk32, unf32;
    logic [2:0]  cnt32;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    pc_sequencer #(.ADDR_W(64), .RAS_DEPTH(DEPTH)) dut64 (
        .CLK(CLK), .resetl(resetl), .StartPC(StartPC), .Advance(Advance),
        .BranchOp(BranchOp), .SignExtImm64(Imm), .ALUZero(ALUZero),
        .CondTrue(CondTrue), .RegTarget(RegTarget), .Redirect(Redirect),
        .RedirectPC(RedirectPC), .CurrentPC(cur64), .NextPC(nxt64),
        .Taken(tk64), .RasCount(cnt64), .RasUnderflow(unf64)
    );

    pc_sequencer #(.ADDR_W(32), .RAS_DEPTH(DEPTH)) dut32 (
        .CLK(CLK), .resetl(resetl), .StartPC(StartPC[31:0]), .Advance(Advance),
        .BranchOp(BranchOp), .SignExtImm64(Imm), .ALUZero(ALUZero),
        .CondTrue(CondTrue), .RegTarget(RegTarget[31:0]), .Redirect(Redirect),
        .RedirectPC(RedirectPC[31:0]), .CurrentPC(cur32), .NextPC(nxt32),
        .Taken(tk32), .RasCount(cnt32), .RasUnderflow(unf32)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model state: the value each DUT register must hold after the last edge.
    bit          m_valid = 0;
    logic [63:0] m_pc;
    bit          m_taken, m_unf;
    logic [63:0] m_ras[$];

    function automatic logic [63:0] mdl_next();
        logic [63:0] seq, rel;
        seq = m_pc + 64'd4;
        rel = m_pc + (Imm << 2);
        if (Redirect) return RedirectPC;
        case (BranchOp)
            B, BL:  return rel;
            CBZ:    return ALUZero ? rel : seq;
            CBNZ:   return !ALUZero ? rel : seq;
            BCOND:  return CondTrue ? rel : seq;
            BR:     return RegTarget;
            RET:    return (m_ras.size() > 0) ? m_ras[$] : RegTarget;
            default: return seq;
        endcase
    endfunction

    function automatic bit mdl_taken();
        if (Redirect) return 1'b1;
        case (BranchOp)
            B, BL, BR, RET: return 1'b1;
            CBZ:   return ALUZero;
            CBNZ:  return !ALUZero;
            BCOND: return CondTrue;
            default: return 1'b0;
        endcase
    endfunction

    // Compare on the falling edge, then step the model with the inputs the next rising edge samples.
    always @(negedge CLK) begin
        logic [63:0] nx;
        bit tk;
        if (m_valid) begin
            nx = mdl_next();
            chk("cur64", cur64, m_pc);
            chk("next64", nxt64, nx);
            chk("taken64", {63'd0, tk64}, {63'd0, m_taken});
            chk("cnt64", {61'd0, cnt64}, 64'(m_ras.size()));
            chk("unf64", {63'd0, unf64}, {63'd0, m_unf});
            chk("cur32", {32'd0, cur32}, {32'd0, m_pc[31:0]});
            chk("next32", {32'd0, nxt32}, {32'd0, nx[31:0]});
            chk("taken32", {63'd0, tk32}, {63'd0, m_taken});
            chk("cnt32", {61'd0, cnt32}, 64'(m_ras.size()));
            chk("unf32", {63'd0, unf32}, {63'd0, m_unf});
        end
        if (!resetl) begin
            m_pc    = StartPC;
            m_taken = 0;
            m_unf   = 0;
            m_ras.delete();
            m_valid = 1;
        end else if (m_valid && Advance) begin
            nx = mdl_next();
            tk = mdl_taken();
            if (!Redirect) begin
                if (BranchOp == BL) begin
                    if (m_ras.size() == DEPTH) void'(m_ras.pop_front());
                    m_ras.push_back(m_pc + 64'd4);
                end else if (BranchOp == RET) begin
                    if (m_ras.size() > 0) void'(m_ras.pop_back());
                    else m_unf = 1;
                end
            end
            m_pc    = nx;
            m_taken = tk;
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic step(input logic [2:0] o, input logic [63:0] imm);
        resetl = 1; Advance = 1; Redirect = 0; BranchOp = o; Imm = imm;
        tick();
    endtask

    task automatic redir(input logic [63:0] t);
        resetl = 1; Advance = 1; Redirect = 1; RedirectPC = t; BranchOp = SEQ;
        tick();
        Redirect = 0;
    endtask

    initial begin
        resetl = 0; StartPC = 64'h1000; Advance = 1; BranchOp = BL; Imm = 64'd3;
        ALUZero = 0; CondTrue = 0; RegTarget = 64'h7770; Redirect = 1; RedirectPC = 64'h5555;
        tick();
        tick();
        chk("rst_pc", cur64, 64'h1000);
        chk("rst_taken", {63'd0, tk64}, 64'd0);
        chk("rst_cnt", {61'd0, cnt64}, 64'd0);
        chk("rst_unf", {63'd0, unf64}, 64'd0);

        step(SEQ, 0); chk("seq1", cur64, 64'h1004);
        step(SEQ, 0); chk("seq2", cur64, 64'h1008);
        step(SEQ, 0); chk("seq3", cur64, 64'h100C);
        chk("seq_taken", {63'd0, tk64}, 64'd0);

        redir(64'h2000); chk("redir_pc", cur64, 64'h2000);
        chk("redir_taken", {63'd0, tk64}, 64'd1);
        ALUZero = 1; step(CBZ, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("cbz_t_pc", cur64, 64'h1FF0); chk("cbz_t_taken", {63'd0, tk64}, 64'd1);
        redir(64'h2000);
        ALUZero = 0; step(CBZ, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("cbz_nt_pc", cur64, 64'h2004); chk("cbz_nt_taken", {63'd0, tk64}, 64'd0);
        step(CBNZ, 64'd8);  chk("cbnz_pc", cur64, 64'h2024);
        CondTrue = 0; step(BCOND, 64'd8); chk("bcond_nt", cur64, 64'h2028);
        CondTrue = 1; step(BCOND, 64'd4); chk("bcond_t", cur64, 64'h2038);
        step(B, 64'd1);
        chk("b_seqval_pc", cur64, 64'h203C); chk("b_seqval_taken", {63'd0, tk64}, 64'd1);
        RegTarget = 64'h3000; step(BR, 0); chk("br_pc", cur64, 64'h3000);

        redir(64'h100);
        step(BL, 64'h40); chk("bl1_pc", cur64, 64'h200); chk("bl1_cnt", {61'd0, cnt64}, 64'd1);
        step(BL, 64'h10); chk("bl2_pc", cur64, 64'h240); chk("bl2_cnt", {61'd0, cnt64}, 64'd2);
        step(RET, 0);     chk("ret1_pc", cur64, 64'h204); chk("ret1_cnt", {61'd0, cnt64}, 64'd1);
        step(RET, 0);     chk("ret2_pc", cur64, 64'h104); chk("ret2_cnt", {61'd0, cnt64}, 64'd0);

        redir(64'h1000);
        for (int i = 0; i < 5; i++) step(BL, 64'h100);
        chk("bl5_pc", cur64, 64'h2400); chk("bl5_cnt", {61'd0, cnt64}, 64'd4);
        RegTarget = 64'h7770;
        step(RET, 0); chk("ovf_ret1", cur64, 64'h2004);
        step(RET, 0); chk("ovf_ret2", cur64, 64'h1C04);
        step(RET, 0); chk("ovf_ret3", cur64, 64'h1804);
        step(RET, 0); chk("ovf_ret4", cur64, 64'h1404);
        chk("ovf_unf_pre", {63'd0, unf64}, 64'd0);
        step(RET, 0); chk("ovf_ret5", cur64, 64'h7770);
        chk("ovf_unf", {63'd0, unf64}, 64'd1);
        step(SEQ, 0); chk("unf_sticky", {63'd0, unf64}, 64'd1);

        step(BL, 0); step(BL, 0);
        chk("pre_hold_pc", cur64, 64'h7774);
        Advance = 0; BranchOp = BL; Imm = 64'h40;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_pc", cur64, 64'h7774);
            chk("hold_cnt", {61'd0, cnt64}, 64'd2);
        end
        Advance = 1; Redirect = 1; RedirectPC = 64'h8000; BranchOp = RET;
        tick();
        chk("redir_ret_pc", cur64, 64'h8000); chk("redir_ret_cnt", {61'd0, cnt64}, 64'd2);
        Redirect = 0;

        resetl = 0; StartPC = 64'hFFFF_FFFC; Advance = 1; BranchOp = BL;
        tick();
        chk("midrst_cnt", {61'd0, cnt64}, 64'd0);
        chk("midrst_unf", {63'd0, unf64}, 64'd0);
        chk("midrst_pc", cur64, 64'hFFFF_FFFC);
        step(SEQ, 0);
        chk("wrap32", {32'd0, cur32}, 64'd0);
        chk("nowrap64", cur64, 64'h1_0000_0000);
        RegTarget = 64'h1234_5678;
        step(RET, 0); chk("ret_empty_pc", cur64, 64'h1234_5678);
        step(SEQ, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
